// File: rtl/bdd_tree_engine.sv
// Decision-tree / BDD traversal engine: walks a software-loaded node RAM using a
// latched feature vector and reports the leaf class (or an abort) on valid/ready.
module bdd_tree_engine #(
  parameter int N_ATTR    = 4,
  parameter int ATTR_W    = 10,
  parameter int ADDR_W    = 5,
  parameter int CLASS_W   = 8,
  parameter int MAX_DEPTH = 16,
  localparam int AIDX_W   = $clog2(N_ATTR),
  localparam int NODE_W   = 1 + AIDX_W + ATTR_W + 2 * ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [NODE_W-1:0]        cfg_wdata,
  input  logic [ADDR_W-1:0]        cfg_root,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_ATTR*ATTR_W-1:0] in_attrs,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err,
  output logic [7:0]               out_depth,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

  state_t                   state, state_next;
  logic [NODE_W-1:0]        mem [2**ADDR_W];
  logic [NODE_W-1:0]        rd_data;
  logic [ADDR_W-1:0]        cur_addr;
  logic [N_ATTR*ATTR_W-1:0] attrs_q;

  logic                     node_leaf;
  logic [AIDX_W-1:0]        node_sel;
  logic [ATTR_W-1:0]        node_thr;
  logic [ADDR_W-1:0]        node_left;
  logic [ADDR_W-1:0]        node_right;
  logic                     sel_bad;
  logic [ATTR_W-1:0]        attr_val;
  logic [7:0]               depth_inc;
  logic                     depth_hit;
  logic                     accept;

  assign node_leaf  = rd_data[NODE_W-1];
  assign node_sel   = rd_data[NODE_W-2 -: AIDX_W];
  assign node_thr   = rd_data[2*ADDR_W+ATTR_W-1 -: ATTR_W];
  assign node_left  = rd_data[2*ADDR_W-1 -: ADDR_W];
  assign node_right = rd_data[ADDR_W-1:0];

  // attr_sel can encode values past N_ATTR when N_ATTR is not a power of two
  assign sel_bad   = (32'(node_sel) >= N_ATTR);
  assign depth_inc = out_depth + 8'd1;
  assign depth_hit = (depth_inc == 8'(MAX_DEPTH));

  assign in_ready  = (state == IDLE) && !cfg_we;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    attr_val = '0;
    for (int k = 0; k < N_ATTR; k++) begin
      if (32'(node_sel) == k) attr_val = attrs_q[k*ATTR_W +: ATTR_W];
    end
  end

  // Node RAM has no reset so software-loaded trees survive rst
  always_ff @(posedge clk) begin
    if (cfg_we && (state == IDLE)) mem[cfg_addr] <= cfg_wdata;
    rd_data <= mem[cur_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = FETCH;
      FETCH: state_next = EVAL;
      EVAL: begin
        if (node_leaf || sel_bad || depth_hit) state_next = DONE;
        else                                   state_next = FETCH;
      end
      DONE:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_class <= '0;
      out_err   <= 1'b0;
      out_depth <= '0;
      cur_addr  <= '0;
      attrs_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            attrs_q   <= in_attrs;
            cur_addr  <= cfg_root;
            out_depth <= '0;
            out_class <= '0;
            out_err   <= 1'b0;
          end
        end
        EVAL: begin
          if (node_leaf) begin
            out_class <= rd_data[CLASS_W-1:0];
            out_err   <= 1'b0;
          end else if (sel_bad) begin
            out_class <= '0;
            out_err   <= 1'b1;
          end else begin
            out_depth <= depth_inc;
            cur_addr  <= (attr_val < node_thr) ? node_left : node_right;
            if (depth_hit) begin
              out_class <= '0;
              out_err   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bdd_tree_engine.sv
// Directed bench for bdd_tree_engine: a default build plus an N_ATTR=3 build
// sharing one config/input bus so the out-of-range attr_sel abort can be exercised.
module tb_bdd_tree_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [22:0] cfg_wdata;
  logic [4:0]  cfg_root;
  logic        in_valid;
  logic [39:0] in_attrs;
  logic [29:0] in_attrs3;
  logic        out_ready;

  logic        in_ready, out_valid, out_err, busy;
  logic [7:0]  out_class, out_depth;
  logic        in_ready3, out_valid3, out_err3, busy3;
  logic [7:0]  out_class3, out_depth3;

  int checks = 0;
  int errors = 0;
  int lat4, lat3;
  int seen_valid;

  assign in_attrs3 = in_attrs[29:0];

  always #5 clk = ~clk;

  bdd_tree_engine u_dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_root(cfg_root), .in_valid(in_valid), .in_ready(in_ready), .in_attrs(in_attrs),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_err(out_err), .out_depth(out_depth), .busy(busy)
  );

  bdd_tree_engine #(.N_ATTR(3)) u_dut3 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_root(cfg_root), .in_valid(in_valid), .in_ready(in_ready3), .in_attrs(in_attrs3),
    .out_valid(out_valid3), .out_ready(out_ready), .out_class(out_class3),
    .out_err(out_err3), .out_depth(out_depth3), .busy(busy3)
  );

  function automatic logic [22:0] inode(input int sel, input int thr, input int l, input int r);
    return {1'b0, 2'(sel), 10'(thr), 5'(l), 5'(r)};
  endfunction

  function automatic logic [22:0] leafn(input int cls);
    return {1'b1, 14'd0, 8'(cls)};
  endfunction

  function automatic logic [39:0] pack(input int a0, input int a1, input int a2, input int a3);
    return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic cfgWrite(input int addr, input logic [22:0] data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 5'(addr); cfg_wdata = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Leaves the DUTs one edge past the accept edge (state FETCH)
  task automatic startVector(input logic [39:0] attrs, input int root);
    @(negedge clk);
    in_attrs = attrs; cfg_root = 5'(root); in_valid = 1'b1;
    #1;
    checkOutput("in_ready_at_accept", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Latency counts edges from the accept edge (=1) to the edge that raised out_valid
  task automatic waitResult();
    lat4 = 0; lat3 = 0;
    for (int e = 1; e <= 200; e++) begin
      if (out_valid  && lat4 == 0) lat4 = e;
      if (out_valid3 && lat3 == 0) lat3 = e;
      if (lat4 != 0 && lat3 != 0) break;
      @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input logic [39:0] attrs, input int root);
    startVector(attrs, root);
    waitResult();
  endtask

  task automatic releaseResult();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("released_out_valid", 32'(out_valid), 0);
    checkOutput("released_busy", 32'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_root = '0;
    in_valid = 1'b0; in_attrs = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 0);
    checkOutput("reset_out_class", 32'(out_class), 0);
    checkOutput("reset_out_err",   32'(out_err), 0);
    checkOutput("reset_out_depth", 32'(out_depth), 0);
    checkOutput("reset_busy",      32'(busy), 0);
    checkOutput("reset_in_ready",  32'(in_ready), 1);
    rst = 1'b0;

    cfgWrite(0, inode(0, 245, 1, 2));
    cfgWrite(1, leafn(3));
    cfgWrite(2, inode(1, 175, 3, 4));
    cfgWrite(3, leafn(5));
    cfgWrite(4, leafn(7));
    cfgWrite(5, inode(0, 0, 5, 5));
    cfgWrite(6, inode(3, 0, 0, 0));

    applyStimulus(pack(49, 0, 0, 0), 0);
    checkOutput("a49_class",   32'(out_class), 3);
    checkOutput("a49_err",     32'(out_err), 0);
    checkOutput("a49_depth",   32'(out_depth), 1);
    checkOutput("a49_latency", 32'(lat4), 5);
    releaseResult();

    applyStimulus(pack(300, 30, 0, 0), 0);
    checkOutput("a300_30_class",   32'(out_class), 5);
    checkOutput("a300_30_err",     32'(out_err), 0);
    checkOutput("a300_30_depth",   32'(out_depth), 2);
    checkOutput("a300_30_latency", 32'(lat4), 7);
    releaseResult();

    applyStimulus(pack(300, 175, 0, 0), 0);
    checkOutput("a300_175_class", 32'(out_class), 7);
    checkOutput("a300_175_err",   32'(out_err), 0);
    checkOutput("a300_175_depth", 32'(out_depth), 2);
    releaseResult();

    // Backpressure: result must hold and a new vector must not be taken
    applyStimulus(pack(49, 0, 0, 0), 0);
    in_valid = 1'b1; in_attrs = pack(300, 30, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hold_out_valid", 32'(out_valid), 1);
      checkOutput("hold_out_class", 32'(out_class), 3);
      checkOutput("hold_in_ready",  32'(in_ready), 0);
    end
    in_valid = 1'b0;
    checkOutput("hold_out_depth", 32'(out_depth), 1);
    releaseResult();

    applyStimulus(pack(49, 0, 0, 0), 5);
    checkOutput("loop_err",     32'(out_err), 1);
    checkOutput("loop_class",   32'(out_class), 0);
    checkOutput("loop_depth",   32'(out_depth), 16);
    checkOutput("loop_latency", 32'(lat4), 33);
    releaseResult();

    applyStimulus(pack(49, 0, 0, 0), 6);
    checkOutput("badsel_err",      32'(out_err3), 1);
    checkOutput("badsel_class",    32'(out_class3), 0);
    checkOutput("badsel_depth",    32'(out_depth3), 0);
    checkOutput("badsel_latency",  32'(lat3), 3);
    checkOutput("sel3_n4_class",   32'(out_class), 3);
    checkOutput("sel3_n4_depth",   32'(out_depth), 2);
    checkOutput("sel3_n4_latency", 32'(lat4), 7);
    releaseResult();

    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 5'd7; cfg_wdata = leafn(1);
    in_valid = 1'b1; in_attrs = pack(49, 0, 0, 0); cfg_root = 5'd0;
    #1;
    checkOutput("write_wins_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    cfg_we = 1'b0; in_valid = 1'b0;
    checkOutput("write_wins_busy", 32'(busy), 0);

    startVector(pack(49, 0, 0, 0), 0);
    cfg_we = 1'b1; cfg_addr = 5'd1; cfg_wdata = leafn(9);
    @(negedge clk);
    cfg_we = 1'b0;
    waitResult();
    checkOutput("busy_write_class", 32'(out_class), 3);
    releaseResult();
    applyStimulus(pack(49, 0, 0, 0), 0);
    checkOutput("busy_write_rerun_class", 32'(out_class), 3);
    releaseResult();

    // Reset while the first node is being evaluated
    startVector(pack(300, 30, 0, 0), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy",      32'(busy), 0);
    checkOutput("midrst_out_valid", 32'(out_valid), 0);
    checkOutput("midrst_in_ready",  32'(in_ready), 1);
    rst = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    checkOutput("midrst_no_output", 32'(seen_valid), 0);
    applyStimulus(pack(49, 0, 0, 0), 0);
    checkOutput("rerun_class",   32'(out_class), 3);
    checkOutput("rerun_depth",   32'(out_depth), 1);
    checkOutput("rerun_latency", 32'(lat4), 5);
    releaseResult();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
